// File: rtl/rx_dcoffset_mc.sv
// Multi-channel RX DC-offset canceller: each channel subtracts a quantised
// leaky-integrator offset estimate; a settings-bus FSM selects FIXED / ACQ / TRACK.
module rx_dcoffset_mc #(
  parameter int         WIDTH     = 16,
  parameter int         NUM_CH    = 2,
  parameter logic [7:0] ADDR      = 8'd0,
  parameter int         MAX_SHIFT = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    in_stb,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    out_stb,
  output logic [WIDTH-1:0]        offset_rb,
  output logic                    acq_active
);
  localparam int IW = WIDTH + MAX_SHIFT;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW:0] HALF = {{(IW-MAX_SHIFT+1){1'b0}}, 1'b1, {(MAX_SHIFT-1){1'b0}}};

  typedef enum logic [1:0] {ST_FIXED = 2'd0, ST_ACQ = 2'd1, ST_TRACK = 2'd2} state_t;

  state_t      state;
  logic [4:0]  acq_shift;
  logic [4:0]  trk_shift;
  logic [15:0] acq_len;
  logic [15:0] acq_cnt;
  logic [3:0]  rb_sel;

  logic wr_ctrl, wr_len, wr_load, wr_rb;
  assign wr_ctrl = set_stb && (set_addr == ADDR);
  assign wr_len  = set_stb && (set_addr == ADDR + 8'd1);
  assign wr_load = set_stb && (set_addr == ADDR + 8'd2);
  assign wr_rb   = set_stb && (set_addr == ADDR + 8'd3);

  logic unused_set_bits;
  assign unused_set_bits = ^set_data;

  // Mode machine plus settings registers; a CTRL write overrides the ACQ terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_TRACK;
      acq_active <= 1'b0;
      acq_cnt    <= '0;
      acq_shift  <= 5'd12;
      trk_shift  <= 5'd20;
      acq_len    <= 16'd1024;
      rb_sel     <= '0;
    end else begin
      if (wr_ctrl) begin
        acq_shift <= set_data[12:8];
        trk_shift <= set_data[20:16];
      end
      if (wr_len) acq_len <= set_data[15:0];
      if (wr_rb)  rb_sel  <= set_data[3:0];

      if (wr_ctrl) begin
        acq_cnt <= '0;
        if (set_data[1:0] == 2'd0 || (set_data[1:0] == 2'd2 && acq_len == 16'd0)) begin
          state      <= ST_TRACK;
          acq_active <= 1'b0;
        end else if (set_data[1:0] == 2'd2) begin
          state      <= ST_ACQ;
          acq_active <= 1'b1;
        end else begin
          state      <= ST_FIXED;
          acq_active <= 1'b0;
        end
      end else if (state == ST_ACQ && in_stb) begin
        if ({1'b0, acq_cnt} + 17'd1 >= {1'b0, acq_len}) begin
          state      <= ST_TRACK;
          acq_active <= 1'b0;
        end else begin
          acq_cnt <= acq_cnt + 16'd1;
        end
      end
    end
  end

  logic [4:0] raw_shift;
  logic [5:0] eff_shift;
  logic [5:0] step_sh;
  always_comb begin
    raw_shift = (state == ST_ACQ) ? acq_shift : trk_shift;
    if (raw_shift == 5'd0)                           eff_shift = 6'd1;
    else if ({1'b0, raw_shift} > 6'(MAX_SHIFT))      eff_shift = 6'(MAX_SHIFT);
    else                                             eff_shift = {1'b0, raw_shift};
    step_sh = 6'(MAX_SHIFT) - eff_shift;
  end

  logic [IW-1:0]    integ    [NUM_CH];
  logic [WIDTH-1:0] off_q    [NUM_CH];
  logic [WIDTH-1:0] off_next [NUM_CH];
  logic [3:0]       load_ch;
  assign load_ch = set_data[27:24];

  // LOAD takes priority over the leaky update for the addressed channel only.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst)
        integ[k] <= '0;
      else if (wr_load && load_ch == 4'(k))
        integ[k] <= {set_data[WIDTH-1:0], {MAX_SHIFT{1'b0}}};
      else if (out_stb && state != ST_FIXED)
        integ[k] <= integ[k] + ({{MAX_SHIFT{out_data[k*WIDTH+WIDTH-1]}},
                                 out_data[k*WIDTH +: WIDTH]} << step_sh);
    end
  end

  logic [NUM_CH*WIDTH-1:0] in_r;
  logic                    stb1;
  logic [NUM_CH*WIDTH-1:0] clip_all;
  logic [WIDTH-1:0]        rb_val;

  // Round-half-up quantisation of the integrator and the clipped correction, both
  // carried one bit wider so overflow shows up as a sign/MSB disagreement.
  always_comb begin
    logic [IW:0]    rnd;
    logic [WIDTH:0] q;
    logic [WIDTH:0] d;
    rnd      = '0;
    q        = '0;
    d        = '0;
    clip_all = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rnd = {integ[k][IW-1], integ[k]} + HALF;
      q   = rnd[IW:MAX_SHIFT];
      off_next[k] = (q[WIDTH] != q[WIDTH-1]) ? (q[WIDTH] ? SAT_MIN : SAT_MAX) : q[WIDTH-1:0];
      d = {in_r[k*WIDTH+WIDTH-1], in_r[k*WIDTH +: WIDTH]} - {off_q[k][WIDTH-1], off_q[k]};
      clip_all[k*WIDTH +: WIDTH] = (d[WIDTH] != d[WIDTH-1]) ? (d[WIDTH] ? SAT_MIN : SAT_MAX)
                                                             : d[WIDTH-1:0];
    end
  end

  always_comb begin
    rb_val = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (rb_sel == 4'(k)) rb_val = off_q[k];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++)
      off_q[k] <= rst ? '0 : off_next[k];
    offset_rb <= rst ? '0 : rb_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_r     <= '0;
      stb1     <= 1'b0;
      out_data <= '0;
      out_stb  <= 1'b0;
    end else begin
      stb1    <= in_stb;
      out_stb <= stb1;
      if (in_stb) in_r     <= in_data;
      if (stb1)   out_data <= clip_all;
    end
  end
endmodule

// File: tb/tb_rx_dcoffset_mc.sv
// Self-checking bench for rx_dcoffset_mc: randomized isolated samples and streams
// checked against a transaction-level integrator/quantiser model.
module tb_rx_dcoffset_mc;
  localparam int WIDTH = 16;
  localparam int NUM_CH = 2;
  localparam int MAX_SHIFT = 24;
  localparam int IW = WIDTH + MAX_SHIFT;
  localparam int W = NUM_CH * WIDTH;
  localparam logic [7:0] ADDR = 8'd0;
  localparam longint MAXV = (longint'(1) <<< (WIDTH-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (WIDTH-1));

  logic clk = 1'b0;
  logic rst;
  logic set_stb;
  logic [7:0] set_addr;
  logic [31:0] set_data;
  logic [W-1:0] in_data;
  logic in_stb;
  logic [W-1:0] out_data;
  logic out_stb;
  logic [WIDTH-1:0] offset_rb;
  logic acq_active;

  rx_dcoffset_mc #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ADDR(ADDR), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_data(in_data), .in_stb(in_stb), .out_data(out_data), .out_stb(out_stb),
    .offset_rb(offset_rb), .acq_active(acq_active)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model
  longint m_integ [NUM_CH];
  bit     m_frozen;
  int     m_shift;

  function automatic longint sx(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint wrap_iw(input longint v);
    return (v <<< (64 - IW)) >>> (64 - IW);
  endfunction
  function automatic longint clipw(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction
  function automatic int clamp_shift(input int s);
    if (s == 0) return 1;
    if (s > MAX_SHIFT) return MAX_SHIFT;
    return s;
  endfunction
  function automatic longint m_offset(input int k);
    return clipw((m_integ[k] + (longint'(1) <<< (MAX_SHIFT-1))) >>> MAX_SHIFT);
  endfunction
  function automatic logic [W-1:0] predict(input logic [W-1:0] vin);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++)
      r[k*WIDTH +: WIDTH] = WIDTH'(clipw(sx(vin[k*WIDTH +: WIDTH]) - m_offset(k)));
    return r;
  endfunction
  function automatic logic [WIDTH-1:0] rand_sample();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return WIDTH'($urandom_range(0, 65535));
    endcase
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;
  bit sb_en = 1'b1;
  int n_seen = 0;
  int n_exp = 0;

  always @(negedge clk) begin
    if (!rst && out_stb) begin
      last_out = out_data;
      if (sb_en) begin
        n_seen++;
        if (exp_q.size() > 0) check("out_data", longint'(out_data), longint'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic set_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  task automatic write_ctrl(input int mode, input int acq_s, input int trk_s);
    set_write(ADDR, 32'((trk_s << 16) | (acq_s << 8) | mode));
    m_frozen = (mode == 1 || mode == 3);
    m_shift  = clamp_shift(trk_s);
  endtask

  task automatic load(input int ch, input logic [WIDTH-1:0] val);
    set_write(ADDR + 8'd2, 32'((ch << 24) | int'(val)));
    if (ch < NUM_CH) m_integ[ch] = wrap_iw(sx(val) <<< MAX_SHIFT);
  endtask

  task automatic readback(input int k, input string tag, input longint exp);
    set_write(ADDR + 8'd3, 32'(k));
    repeat (3) @(negedge clk);
    check(tag, sx(offset_rb), exp);
  endtask

  task automatic send_sample(input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] qv);
    logic [W-1:0] vin, vexp;
    vin  = {qv, iv};
    vexp = predict(vin);
    exp_q.push_back(vexp); n_exp++;
    @(negedge clk); in_data = vin; in_stb = 1'b1;
    @(negedge clk); in_stb = 1'b0; check("stb_lat1", out_stb, 0);
    @(negedge clk); check("stb_lat2", out_stb, 1);
    @(negedge clk); check("stb_lat3", out_stb, 0); check("out_hold", longint'(out_data), longint'(vexp));
    repeat (6) @(negedge clk);
    if (!m_frozen)
      for (int k = 0; k < NUM_CH; k++)
        m_integ[k] = wrap_iw(m_integ[k] + (sx(vexp[k*WIDTH +: WIDTH]) <<< (MAX_SHIFT - m_shift)));
  endtask

  task automatic stream(input int n, input bit use_sb, input bit i_rand,
                        input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] qv);
    logic [W-1:0] vin;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vin = {qv, i_rand ? rand_sample() : iv};
      if (use_sb) begin exp_q.push_back(predict(vin)); n_exp++; end
      in_data = vin; in_stb = 1'b1;
    end
    @(negedge clk); in_stb = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic count_acq(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (acq_active) cnt++;
      in_data = {16'd2000, 16'd2000}; in_stb = 1'b1;
    end
    @(negedge clk); in_stb = 1'b0;
  endtask

  initial begin
    int cnt, cnt2;
    bit saw;
    logic [WIDTH-1:0] v0, v1;
    rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_stb = 1'b1; in_data = W'($urandom);
    for (int k = 0; k < NUM_CH; k++) m_integ[k] = 0;
    m_frozen = 1'b0; m_shift = 20;

    // reset with strobes active, then a sample dropped by a reset mid-flight
    repeat (4) @(negedge clk);
    check("rst_out_stb", out_stb, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_offset_rb", longint'(offset_rb), 0);
    check("rst_acq_active", acq_active, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; in_stb = 1'b0;
    saw = 1'b0;
    repeat (4) begin @(negedge clk); saw |= out_stb; end
    check("inflight_dropped", saw, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    send_sample(16'd1000, 16'(-500));
    check("first_i", sx(last_out[15:0]), 1000);

    // randomized TRACK with a range of shifts, including the clamped 0 and 31
    for (int r = 0; r < 6; r++) begin
      int ts;
      ts = (r == 0) ? 0 : (r == 1) ? 31 : $urandom_range(1, MAX_SHIFT);
      write_ctrl(0, $urandom_range(0, 31), ts);
      for (int n = 0; n < 5; n++) begin
        send_sample(rand_sample(), rand_sample());
        readback(0, "trk_off0", m_offset(0));
        readback(1, "trk_off1", m_offset(1));
      end
    end

    // LOAD colliding with an integrator update
    write_ctrl(0, 12, 4);
    v0 = WIDTH'($urandom_range(4000, 20000));
    v1 = WIDTH'(-$urandom_range(4000, 20000));
    begin
      logic [W-1:0] vexp;
      vexp = predict({v1, v0});
      exp_q.push_back(vexp); n_exp++;
      @(negedge clk); in_data = {v1, v0}; in_stb = 1'b1;
      @(negedge clk); in_stb = 1'b0;
      @(negedge clk); check("coll_out_stb", out_stb, 1);
      set_stb = 1'b1; set_addr = ADDR + 8'd2; set_data = 32'(50);
      @(negedge clk); set_stb = 1'b0;
      m_integ[0] = longint'(50) <<< MAX_SHIFT;
      m_integ[1] = wrap_iw(m_integ[1] + (sx(vexp[WIDTH +: WIDTH]) <<< (MAX_SHIFT - 4)));
    end
    repeat (4) @(negedge clk);
    readback(0, "coll_off0", 50);
    readback(1, "coll_off1", m_offset(1));

    // FIXED mode with loaded offsets
    write_ctrl(1, 12, 20);
    load(1, 16'd300);
    load(0, WIDTH'($urandom_range(0, 400)));
    stream(10000, 1'b1, 1'b1, '0, 16'd300);
    check("fixed_q0", sx(last_out[31:16]), 0);
    readback(1, "fixed_frozen1", 300);
    readback(0, "fixed_frozen0", m_offset(0));
    stream(200, 1'b1, 1'b1, '0, 16'd400);
    check("fixed_q400", sx(last_out[31:16]), 100);
    write_ctrl(3, 12, 20);
    stream(50, 1'b1, 1'b1, '0, rand_sample());
    readback(1, "mode3_frozen1", 300);
    load(5, 16'd777);
    readback(0, "load_bad_ch0", m_offset(0));
    readback(1, "load_bad_ch1", 300);
    readback(5, "rb_bad_sel", 0);

    // clipping without wrap
    load(0, 16'd100);
    stream(8, 1'b1, 1'b0, 16'h8000, 16'd0);
    check("clip_low", sx(last_out[15:0]), -32768);
    load(0, 16'(-100));
    stream(8, 1'b1, 1'b0, 16'h7fff, 16'd0);
    check("clip_high", sx(last_out[15:0]), 32767);

    // TRACK convergence
    load(0, 16'd0);
    load(1, 16'd0);
    sb_en = 1'b0;
    write_ctrl(0, 12, 8);
    stream(4000, 1'b0, 1'b0, 16'd1000, 16'(-500));
    check("conv_i_small", (sx(last_out[15:0]) <= 1 && sx(last_out[15:0]) >= -1), 1);
    check("conv_q_small", (sx(last_out[31:16]) <= 1 && sx(last_out[31:16]) >= -1), 1);
    readback(0, "conv_off0", 1000);
    readback(1, "conv_off1", -500);

    // AUTO acquisition
    write_ctrl(1, 12, 20);
    load(0, 16'd0);
    load(1, 16'd0);
    set_write(ADDR + 8'd1, 32'd64);
    write_ctrl(2, 4, 20);
    count_acq(100, cnt);
    check("acq_len64", cnt, 64);
    check("acq_done", acq_active, 0);
    set_write(ADDR + 8'd3, 32'd0);
    repeat (3) @(negedge clk);
    check("acq_fast_shift", sx(offset_rb) > 1500, 1);

    write_ctrl(2, 4, 20);
    count_acq(30, cnt);
    check("acq_pre_restart", cnt, 30);
    write_ctrl(2, 4, 20);
    count_acq(100, cnt);
    check("acq_restart", cnt, 64);

    // CTRL write on the terminal-count strobe wins
    set_write(ADDR + 8'd1, 32'd4);
    write_ctrl(2, 4, 20);
    count_acq(3, cnt);
    @(negedge clk);
    if (acq_active) cnt++;
    in_data = {16'd2000, 16'd2000}; in_stb = 1'b1;
    set_stb = 1'b1; set_addr = ADDR; set_data = 32'((20 << 16) | (4 << 8) | 2);
    @(negedge clk); set_stb = 1'b0; in_stb = 1'b0;
    count_acq(12, cnt2);
    check("acq_ctrl_wins", cnt + cnt2, 8);

    set_write(ADDR + 8'd1, 32'd0);
    write_ctrl(2, 4, 20);
    count_acq(10, cnt);
    check("acq_len0", cnt, 0);

    repeat (5) @(negedge clk);
    check("sb_count", n_seen, n_exp);
    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
